// File: rtl/contrast_stream_if.sv
// Valid/ready pixel stream with end-of-frame marker; master drives the beat, slave returns ready.
interface contrast_stream_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3
);
  logic                       valid;
  logic                       ready;
  logic [CHANNELS*DATA_W-1:0] data;
  logic                       last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/contrast_stream.sv
// Per-frame contrast (bypass/linear/invert) on every channel of a pixel stream, 2-cycle latency, 1 pixel/cycle.
// One global enable advances both stages; output holds while m.ready is low and s.ready follows that enable.
module contrast_stream #(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 3,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  contrast_stream_if.slave      s,
  contrast_stream_if.master     m,
  input  logic [1:0]            cfg_mode,
  input  logic [GAIN_W-1:0]     cfg_gain,
  input  logic [DATA_W-1:0]     cfg_pivot,
  output logic [15:0]           frame_count
);
  localparam int P_W   = DATA_W + GAIN_W + 2;
  localparam int PIX_W = CHANNELS * DATA_W;
  localparam int MAX_V = (1 << DATA_W) - 1;

  logic                     en;
  logic                     acc;
  logic                     in_frame;
  logic [1:0]               act_mode;
  logic [GAIN_W-1:0]        act_gain;
  logic [DATA_W-1:0]        act_pivot;
  logic [1:0]               eff_mode;
  logic [GAIN_W-1:0]        eff_gain;
  logic [DATA_W-1:0]        eff_pivot;
  logic                     s1_valid;
  logic                     s1_last;
  logic [1:0]               s1_mode;
  logic [DATA_W-1:0]        s1_pivot;
  logic signed [P_W-1:0]    s1_val [CHANNELS];
  logic signed [P_W-1:0]    s1_nxt [CHANNELS];
  logic [PIX_W-1:0]         s2_nxt;

  function automatic logic signed [P_W-1:0] stage1(input logic [1:0] mode, input logic [DATA_W-1:0] x,
                                                   input logic [GAIN_W-1:0] gain, input logic [DATA_W-1:0] pivot);
    logic signed [P_W-1:0] d;
    logic signed [P_W-1:0] g;
    d = $signed({{(P_W-DATA_W){1'b0}}, x}) - $signed({{(P_W-DATA_W){1'b0}}, pivot});
    g = $signed({{(P_W-GAIN_W){1'b0}}, gain});
    case (mode)
      2'd1:    return d * g;
      2'd2:    return $signed({{(P_W-DATA_W){1'b0}}, ~x});
      default: return $signed({{(P_W-DATA_W){1'b0}}, x});
    endcase
  endfunction

  // Arithmetic shift floors toward minus infinity before re-centring and clamping.
  function automatic logic [DATA_W-1:0] stage2(input logic [1:0] mode, input logic signed [P_W-1:0] v,
                                               input logic [DATA_W-1:0] pivot);
    logic signed [P_W-1:0] sum;
    sum = (v >>> GAIN_FRAC) + $signed({{(P_W-DATA_W){1'b0}}, pivot});
    if (mode != 2'd1)
      return v[DATA_W-1:0];
    if (sum < 0)
      return '0;
    if (sum > $signed(P_W'(MAX_V)))
      return '1;
    return sum[DATA_W-1:0];
  endfunction

  assign en      = !m.valid || m.ready;
  assign s.ready = en;
  assign acc     = s.valid && en;

  // The first beat of a frame sees the live cfg; later beats see the captured copy.
  assign eff_mode  = in_frame ? act_mode  : cfg_mode;
  assign eff_gain  = in_frame ? act_gain  : cfg_gain;
  assign eff_pivot = in_frame ? act_pivot : cfg_pivot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame  <= 1'b0;
      act_mode  <= '0;
      act_gain  <= '0;
      act_pivot <= '0;
    end else begin
      if (!in_frame) begin
        act_mode  <= cfg_mode;
        act_gain  <= cfg_gain;
        act_pivot <= cfg_pivot;
      end
      if (acc)
        in_frame <= !s.last;
    end
  end

  always_comb begin
    s1_nxt = '{default: '0};
    s2_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s1_nxt[c] = stage1(eff_mode, s.data[(CHANNELS-1-c)*DATA_W +: DATA_W], eff_gain, eff_pivot);
      s2_nxt[(CHANNELS-1-c)*DATA_W +: DATA_W] = stage2(s1_mode, s1_val[c], s1_pivot);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= '0;
      s1_pivot <= '0;
      s1_val   <= '{default: '0};
      m.valid  <= 1'b0;
      m.data   <= '0;
      m.last   <= 1'b0;
    end else if (en) begin
      s1_valid <= s.valid;
      s1_last  <= s.valid && s.last;
      s1_mode  <= eff_mode;
      s1_pivot <= eff_pivot;
      s1_val   <= s1_nxt;
      m.valid  <= s1_valid;
      m.data   <= s2_nxt;
      m.last   <= s1_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_count <= '0;
    else if (m.valid && m.ready && m.last)
      frame_count <= frame_count + 16'd1;
  end
endmodule
